// File: rtl/aes_dec_round_engine.sv
`default_nettype none
// aes_dec_round_engine: iterative AES-256 inverse cipher, one round per clock.
// Revision: 1.0
module aes_dec_round_engine #(
   parameter int NR     = 14,
   parameter int KIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inValid,
   output logic              inReady,
   input  logic [127:0]      inData,
   output logic [KIDX_W-1:0] roundKeyIdx,
   input  logic [127:0]      roundKey,
   output logic              outValid,
   input  logic              outReady,
   output logic [127:0]      outData
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ROUND = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;

   localparam logic [KIDX_W-1:0] c_KIDX_FIRST = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] c_RND_START  = KIDX_W'(NR - 1);

   logic [1:0]        r_fsm;
   logic [KIDX_W-1:0] r_rnd;
   logic [127:0]      r_state;
   logic [127:0]      r_out;

   logic [127:0]      w_sub;
   logic [127:0]      w_ark;
   logic [127:0]      w_mix;
   logic [127:0]      w_next;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse affine transform, then multiplicative inverse computed as b^254.
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      logic [7:0] sq;
      logic [7:0] acc;
      b   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      sq  = b;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // Byte k sits at row k%4, column k/4; InvShiftRows pulls from column (c-r) mod 4.
   for (genvar k = 0; k < 16; k++) begin : g_byte
      localparam int c_ROW = k % 4;
      localparam int c_SRC = 4 * (((k / 4) - c_ROW + 4) % 4) + c_ROW;
      assign w_sub[127-8*k -: 8] = inv_sbox(r_state[127-8*c_SRC -: 8]);
   end

   assign w_ark = w_sub ^ roundKey;

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_ark[127-32*c    -: 8];
      assign w_a1 = w_ark[127-32*c-8  -: 8];
      assign w_a2 = w_ark[127-32*c-16 -: 8];
      assign w_a3 = w_ark[127-32*c-24 -: 8];
      assign w_mix[127-32*c    -: 8] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b) ^
                                       gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
      assign w_mix[127-32*c-8  -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e) ^
                                       gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
      assign w_mix[127-32*c-16 -: 8] = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09) ^
                                       gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
      assign w_mix[127-32*c-24 -: 8] = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d) ^
                                       gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);
   end

   assign w_next = (r_rnd == '0) ? w_ark : w_mix;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm   <= c_IDLE;
         r_rnd   <= '0;
         r_state <= '0;
         r_out   <= '0;
      end else begin
         case (r_fsm)
            c_IDLE: begin
               if (inValid) begin
                  r_state <= inData ^ roundKey;
                  r_rnd   <= c_RND_START;
                  r_fsm   <= c_ROUND;
               end
            end
            c_ROUND: begin
               r_state <= w_next;
               if (r_rnd == '0) begin
                  r_out <= w_ark;
                  r_fsm <= c_DONE;
               end else begin
                  r_rnd <= r_rnd - 1'b1;
               end
            end
            c_DONE: begin
               if (outReady) r_fsm <= c_IDLE;
            end
            default: r_fsm <= c_IDLE;
         endcase
      end
   end

   // The output register only changes on the final round, so outData holds between blocks.
   assign inReady     = (r_fsm == c_IDLE);
   assign outValid    = (r_fsm == c_DONE);
   assign outData     = r_out;
   assign roundKeyIdx = (r_fsm == c_ROUND) ? r_rnd : c_KIDX_FIRST;

endmodule
`default_nettype wire
